parity_run_detector: RTL

//   Parametrised serial-pattern detector, successor to the fixed 6-state Moore detector.

---
 rtl/parity_run_detector_pkg.sv | 10 +
 rtl/parity_run_detector_zero_run_counter.sv | 36 +++
 rtl/parity_run_detector.sv | 83 ++++++++
 3 files changed

// File: rtl/parity_run_detector_pkg.sv
// rtl/parity_run_detector_pkg.sv - shared state and parity-select encodings for the run detector
package parity_run_detector_pkg;
    typedef enum logic {
        ST_SEEK  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/parity_run_detector_zero_run_counter.sv
// rtl/parity_run_detector_zero_run_counter.sv - counts consecutive accepted zeros, flags the RUN_LEN-th
module zero_run_counter #(
    parameter int RUN_LEN = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic rst_run,
    input  logic clear,
    output logic hit
);
    localparam int RUN_W = $clog2(RUN_LEN + 1);

    logic [RUN_W-1:0] run_q, run_d, run_inc;

    assign run_inc = run_q + 1'b1;
    assign hit     = inc && (run_inc == RUN_W'(RUN_LEN));

    // A hit restarts the run, so run_q never exceeds RUN_LEN-1.
    always_comb begin
        run_d = run_q;
        if (clear || rst_run || hit) begin
            run_d = '0;
        end else if (inc) begin
            run_d = run_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/parity_run_detector.sv
// rtl/parity_run_detector.sv - arms on a zero run, then flags even/odd parity of ones since arming
module parity_run_detector
    import parity_run_detector_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             x_valid,
    input  logic             x,
    input  logic             clear,
    input  logic             parity_sel,
    output logic             y,
    output logic             armed,
    output logic             arm_pulse,
    output logic [CNT_W-1:0] arm_cnt
);
    state_e           state_q, state_d;
    logic             parity_q, parity_d;
    logic             arm_pulse_q, arm_pulse_d;
    logic [CNT_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             run_hit, arm_event;

    zero_run_counter #(.RUN_LEN(RUN_LEN)) u_zero_run (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (!clear && x_valid && !x),
        .rst_run (!clear && x_valid && x),
        .clear   (clear),
        .hit     (run_hit)
    );

    always_comb begin
        state_d   = state_q;
        parity_d  = parity_q;
        arm_event = 1'b0;
        if (clear) begin
            state_d  = ST_SEEK;
            parity_d = 1'b0;
        end else if (x_valid) begin
            if (x) begin
                if (state_q == ST_TRACK) begin
                    parity_d = ~parity_q;
                end
            end else if (run_hit) begin
                // Arming from SEEK and re-arming in TRACK share one path.
                state_d   = ST_TRACK;
                parity_d  = 1'b0;
                arm_event = 1'b1;
            end
        end
    end

    always_comb begin
        arm_pulse_d = arm_event;
        arm_cnt_d   = arm_cnt_q;
        if (clear) begin
            arm_cnt_d = '0;
        end else if (arm_event && (arm_cnt_q != {CNT_W{1'b1}})) begin
            arm_cnt_d = arm_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_SEEK;
            parity_q    <= 1'b0;
            arm_pulse_q <= 1'b0;
            arm_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            parity_q    <= parity_d;
            arm_pulse_q <= arm_pulse_d;
            arm_cnt_q   <= arm_cnt_d;
        end
    end

    assign armed     = (state_q == ST_TRACK);
    assign y         = armed && (parity_q == parity_sel);
    assign arm_pulse = arm_pulse_q;
    assign arm_cnt   = arm_cnt_q;
endmodule
